// File: rtl/bus_arbiter_rr_if.sv
// Handshake bundle between requesting masters and the round-robin bus arbiter.
// The master side drives req; the arbiter (slave) drives the grant outputs.
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic [IW-1:0]          grant_id;
  logic                   bus_busy;
  logic                   timeout;

  modport master (output req, input grant, grant_id, bus_busy, timeout);
  modport slave  (input req, output grant, grant_id, bus_busy, timeout);
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter producing one-hot tri-state enables with a forced one-cycle
// all-off turnaround between owners and a hold limit that revokes long grants.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 16
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_rr_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_q, grant_nxt;
  logic [IW-1:0]          owner_q, owner_nxt;
  logic [IW-1:0]          ptr_q, ptr_nxt;
  logic [IW-1:0]          win;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic                   timeout_q, timeout_nxt;
  logic                   busy_q;
  logic                   found;
  logic                   owner_req;
  logic                   hold_done;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && bus.req[IW'((int'(ptr_q) + i) % NUM_MASTERS)]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + i) % NUM_MASTERS);
      end
    end
  end

  assign owner_req = bus.req[owner_q];
  assign hold_done = (cnt_q == CW'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      owner_q   <= owner_nxt;
      ptr_q     <= ptr_nxt;
      cnt_q     <= cnt_nxt;
      timeout_q <= timeout_nxt;
      busy_q    <= |grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, TURN: state_nxt = found ? OWN : IDLE;
      OWN:        state_nxt = (!owner_req || hold_done) ? TURN : OWN;
      default:    state_nxt = IDLE;
    endcase
  end

  // TURN arbitrates exactly like IDLE; leaving OWN always passes through TURN,
  // which is what guarantees the all-off cycle between owners.
  always_comb begin
    grant_nxt   = grant_q;
    owner_nxt   = owner_q;
    ptr_nxt     = ptr_q;
    cnt_nxt     = cnt_q;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (found) begin
          grant_nxt = NUM_MASTERS'(1) << win;
          owner_nxt = win;
          cnt_nxt   = CW'(1);
          ptr_nxt   = (win == IW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
        end else begin
          grant_nxt = '0;
          owner_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (!owner_req || hold_done) begin
          grant_nxt   = '0;
          owner_nxt   = '0;
          cnt_nxt     = '0;
          timeout_nxt = owner_req;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_nxt = '0;
        owner_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = owner_q;
  assign bus.bus_busy = busy_q;
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic against an
// owner/hold-length reference model, on a MAX_HOLD=16 and a MAX_HOLD=1 instance.
module tb_bus_arbiter_rr;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(N)) ifc ();
  bus_arbiter_rr_if #(.NUM_MASTERS(N)) if1 ();
  assign if1.req = ifc.req;

  bus_arbiter_rr #(.NUM_MASTERS(N), .MAX_HOLD(16)) dut0 (.clk(clk), .rst(rst), .bus(ifc));
  bus_arbiter_rr #(.NUM_MASTERS(N), .MAX_HOLD(1))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Reference: current owner (-1 = bus released), cycles owned, RR pointer.
  int   m_owner [2] = '{-1, -1};
  int   m_len   [2] = '{0, 0};
  int   m_ptr   [2] = '{0, 0};
  logic m_to    [2] = '{1'b0, 1'b0};

  function automatic int maxh(int k);
    return (k == 0) ? 16 : 1;
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++)
      if (r[IW'((p + i) % N)]) return (p + i) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] <= -1;
        m_len[k]   <= 0;
        m_ptr[k]   <= 0;
        m_to[k]    <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_owner[k] >= 0) begin
          if (!ifc.req[IW'(m_owner[k])]) begin
            m_owner[k] <= -1;
            m_to[k]    <= 1'b0;
          end else if (m_len[k] == maxh(k)) begin
            m_owner[k] <= -1;
            m_to[k]    <= 1'b1;
          end else begin
            m_len[k] <= m_len[k] + 1;
            m_to[k]  <= 1'b0;
          end
        end else begin
          m_to[k] <= 1'b0;
          if (rr_pick(ifc.req, m_ptr[k]) >= 0) begin
            m_owner[k] <= rr_pick(ifc.req, m_ptr[k]);
            m_len[k]   <= 1;
            m_ptr[k]   <= (rr_pick(ifc.req, m_ptr[k]) + 1) % N;
          end
        end
      end
    end
  end

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    ifc.req = '0;
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout} !== 8'b0) begin
      fails++;
      $display("FAIL reset_async: got %b want 00000000", {ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout});
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if ({ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout} !== 8'b0) begin
      fails++;
      $display("FAIL reset_held: got %b want 00000000", {ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({if1.grant, if1.grant_id, if1.bus_busy, if1.timeout, ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout} !== 16'b0) begin
      fails++;
      $display("FAIL reset_release: got %b want all zero", {if1.grant, if1.grant_id, if1.bus_busy, if1.timeout, ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout});
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    ifc.req = 4'b0100;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      tests++;
      if (c <= 5) begin
        if ({ifc.grant, ifc.grant_id, ifc.bus_busy} !== {4'b0100, 2'd2, 1'b1}) begin
          fails++;
          $display("FAIL single cyc %0d: got grant=%b id=%0d busy=%b want 0100/2/1", c, ifc.grant, ifc.grant_id, ifc.bus_busy);
        end
      end else if ({ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout} !== 8'b0) begin
        fails++;
        $display("FAIL single_release cyc %0d: got grant=%b to=%b want 0000/0", c, ifc.grant, ifc.timeout);
      end
      if (c == 5) ifc.req = '0;
    end
  endtask

  task automatic test_round_robin;
    int   seen = 0;
    int   gap  = 0;
    logic [N-1:0] prev = '0;
    pulse_reset();
    ifc.req = 4'b1111;
    for (int c = 0; c < 40 && seen < 5; c++) begin
      @(negedge clk);
      if (ifc.grant != '0 && prev == '0) begin
        tests++;
        if (int'(ifc.grant_id) != seen % N) begin
          fails++;
          $display("FAIL rr_order #%0d: got %0d want %0d", seen, ifc.grant_id, seen % N);
        end
        if (seen > 0) begin
          tests++;
          if (gap != 1) begin
            fails++;
            $display("FAIL rr_gap #%0d: got %0d want 1", seen, gap);
          end
        end
        seen++;
        gap = 0;
      end else if (ifc.grant == '0) begin
        gap++;
      end
      prev = ifc.grant;
      if (m_owner[0] >= 0 && m_len[0] == 2) ifc.req = 4'b1111 & ~(4'b0001 << m_owner[0]);
      else ifc.req = 4'b1111;
    end
    tests++;
    if (seen != 5) begin
      fails++;
      $display("FAIL rr_count: got %0d grants want 5", seen);
    end
    ifc.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    logic gapc;
    pulse_reset();
    ifc.req = 4'b0001;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      gapc = ((c - 1) % 17) == 16;
      tests++;
      if ({ifc.grant, ifc.timeout} !== {(gapc ? 4'b0000 : 4'b0001), gapc}) begin
        fails++;
        $display("FAIL timeout16 cyc %0d: got grant=%b to=%b want %b/%b", c, ifc.grant, ifc.timeout, gapc ? 4'b0000 : 4'b0001, gapc);
      end
      tests++;
      if ({if1.grant, if1.timeout} !== {((c % 2) ? 4'b0001 : 4'b0000), ~c[0]}) begin
        fails++;
        $display("FAIL timeout1 cyc %0d: got grant=%b to=%b", c, if1.grant, if1.timeout);
      end
    end
    ifc.req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fairness;
    logic [N-1:0] eg;
    logic         et;
    pulse_reset();
    ifc.req = 4'b1001;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      et = ((c - 1) % 17) == 16;
      eg = et ? 4'b0000 : ((((c - 1) / 17) % 2 == 0) ? 4'b0001 : 4'b1000);
      tests++;
      if ({ifc.grant, ifc.timeout} !== {eg, et}) begin
        fails++;
        $display("FAIL fairness cyc %0d: got grant=%b to=%b want %b/%b", c, ifc.grant, ifc.timeout, eg, et);
      end
    end
    ifc.req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    pulse_reset();
    ifc.req = 4'b1000;
    repeat (3) @(negedge clk);
    tests++;
    if (ifc.grant !== 4'b1000) begin
      fails++;
      $display("FAIL midrst_pre: got %b want 1000", ifc.grant);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout} !== 8'b0) begin
      fails++;
      $display("FAIL midrst_async: got %b want 00000000", {ifc.grant, ifc.grant_id, ifc.bus_busy, ifc.timeout});
    end
    ifc.req = 4'b1001;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({ifc.grant, ifc.grant_id} !== {4'b0001, 2'd0}) begin
      fails++;
      $display("FAIL midrst_ptr: got grant=%b id=%0d want 0001/0", ifc.grant, ifc.grant_id);
    end
    ifc.req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    logic [N-1:0]  g, eg;
    logic [N-1:0]  pg [2];
    logic [IW-1:0] gid, eid;
    logic          gb, gt;
    pg[0] = '0;
    pg[1] = '0;
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        g   = (k == 0) ? ifc.grant    : if1.grant;
        gid = (k == 0) ? ifc.grant_id : if1.grant_id;
        gb  = (k == 0) ? ifc.bus_busy : if1.bus_busy;
        gt  = (k == 0) ? ifc.timeout  : if1.timeout;
        eg  = (m_owner[k] >= 0) ? (N'(1) << m_owner[k]) : '0;
        eid = (m_owner[k] >= 0) ? IW'(m_owner[k]) : '0;
        tests++;
        if ({g, gid, gb, gt} !== {eg, eid, |eg, m_to[k]}) begin
          fails++;
          $display("FAIL random dut%0d cyc %0d: got grant=%b id=%0d busy=%b to=%b want grant=%b id=%0d busy=%b to=%b",
                   k, c, g, gid, gb, gt, eg, eid, |eg, m_to[k]);
        end
        tests++;
        if (!$onehot0(g) || (pg[k] != '0 && g != '0 && g != pg[k])) begin
          fails++;
          $display("FAIL handover dut%0d cyc %0d: got %b after %b want onehot0 with gap", k, c, g, pg[k]);
        end
        pg[k] = g;
      end
      if ($urandom_range(0, 19) == 0) ifc.req = N'($urandom_range(0, (1 << N) - 1));
    end
    ifc.req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
